// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle MIPS-subset datapath: sequences IF/ID/EXE/MEM/WB,
// decodes the opcode into datapath controls and counts retired instructions.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_ORI   = 6'b001101,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_HALT  = 6'b111111,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             pc_wre,
  output logic             ir_wre,
  output logic             reg_wre,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             alu_src_b,
  output logic             ext_sel,
  output logic             reg_dst,
  output logic             wb_sel,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_halt, is_unknown;

  always_comb begin
    is_r       = (opcode == OP_RTYPE);
    is_addi    = (opcode == OP_ADDI);
    is_ori     = (opcode == OP_ORI);
    is_lw      = (opcode == OP_LW);
    is_sw      = (opcode == OP_SW);
    is_beq     = (opcode == OP_BEQ);
    is_j       = (opcode == OP_J);
    is_halt    = (opcode == OP_HALT);
    is_unknown = !(is_r || is_addi || is_ori || is_lw || is_sw || is_beq || is_j || is_halt);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_j || is_unknown) begin
          state_d = S_IF;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_r || is_addi || is_ori) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Enables depend on state; the opcode only picks which instruction ends where.
  always_comb begin
    pc_wre  = 1'b0;
    ir_wre  = 1'b0;
    reg_wre = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      S_IF:  ir_wre = 1'b1;
      S_ID:  pc_wre = is_j || is_unknown;
      S_EXE: pc_wre = is_beq;
      S_MEM: begin
        mem_rd = is_lw;
        mem_wr = is_sw;
        pc_wre = is_sw;
      end
      S_WB: begin
        reg_wre = 1'b1;
        pc_wre  = is_r || is_addi || is_ori || is_lw;
      end
      default: pc_wre = 1'b0;
    endcase
    if (Reset) begin
      pc_wre  = 1'b0;
      ir_wre  = 1'b0;
      reg_wre = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
    end else begin
      pc_wre = pc_wre;
    end
  end

  always_comb begin
    alu_src_b = is_addi || is_ori || is_lw || is_sw;
    ext_sel   = !is_ori;
    reg_dst   = is_r;
    wb_sel    = is_lw;
    if (is_r) begin
      alu_op = 2'b10;
    end else if (is_ori) begin
      alu_op = 2'b11;
    end else if (is_beq) begin
      alu_op = 2'b01;
    end else begin
      alu_op = 2'b00;
    end
    if (is_j) begin
      pc_src = 2'b10;
    end else if (is_beq && zero) begin
      pc_src = 2'b01;
    end else begin
      pc_src = 2'b00;
    end
  end

  always_comb begin
    if (pc_wre) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IF;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign instr_cnt = cnt_q;

endmodule
